// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard/forwarding controller:
//   forward-mux select codes, the scoreboard slot record and the helper
//   functions that turn slot contents into select codes and stall requests.
package hazard_ctrl_pkg;

   localparam logic [1:0] RF_RD1 = 2'd0;
   localparam logic [1:0] RF_RD2 = 2'd0;
   localparam logic [1:0] AO_M   = 2'd1;
   localparam logic [1:0] M4     = 2'd2;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] a3;
      logic [1:0] tnew;
      logic       md_start;
      logic       md_op;
   } slot_t;

   localparam int    SLOT_W      = $bits(slot_t);
   localparam slot_t SLOT_BUBBLE = '0;

   // M wins over W; a producer still computing in M is not forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input slot_t      m,
                                          input slot_t      w,
                                          input logic [1:0] rf_code);
      if (src == 5'd0)                          return rf_code;
      if (m.a3 == src && m.tnew == 2'd0)        return AO_M;
      if (w.a3 == src)                          return M4;
      return rf_code;
   endfunction

   function automatic logic reg_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input slot_t      e,
                                       input slot_t      m);
      if (src == 5'd0 || tuse == 2'd3) return 1'b0;
      return (e.a3 == src && e.tnew > tuse) || (m.a3 == src && m.tnew > tuse);
   endfunction

endpackage

// File: rtl/hazard_ctrl_hz_slot.sv
// hz_slot
//   One scoreboard register. Loads din each edge, or a bubble when
//   bubble=1. DEC_TNEW ages tnew by one (saturating at 0); CLR_TNEW
//   forces tnew to 0.
// Ports:
//   clk    in  1       system clock
//   reset  in  1       synchronous, active-low
//   bubble in  1       load an all-zero slot instead of din
//   din    in  SLOT_W  incoming slot record
//   dout   out SLOT_W  registered slot record
module hz_slot
   import hazard_ctrl_pkg::*;
#(
   parameter logic DEC_TNEW = 1'b0,
   parameter logic CLR_TNEW = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bubble,
   input  logic [SLOT_W-1:0] din,
   output logic [SLOT_W-1:0] dout
);

   slot_t din_s;
   slot_t slot_d;
   slot_t slot_q;

   assign din_s = din;

   always_comb begin
      slot_d = din_s;
      if (bubble) begin
         slot_d = SLOT_BUBBLE;
      end else if (CLR_TNEW) begin
         slot_d.tnew = 2'd0;
      end else if (DEC_TNEW && din_s.tnew != 2'd0) begin
         slot_d.tnew = din_s.tnew - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) slot_q <= SLOT_BUBBLE;
      else        slot_q <= slot_d;
   end

   assign dout = slot_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for a five-stage MIPS pipeline.
//   Shadows E/M/W in a scoreboard and derives forward selects, the
//   pipeline stall and multiply/divide busy tracking.
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   d_rs, d_rt, d_a3           D-stage source/destination registers
//   d_tuse_rs, d_tuse_rt       stages until operand use (3 = unused)
//   d_tnew                     cycles until result, counted on E entry
//   d_md_start, d_md_op        D holds mult(0)/div(1)
//   d_is_md                    D holds any HI/LO or mult/div instruction
//   stall                      freeze PC/D, bubble into E
//   mfrsd_c, mfrtd_c           D-stage forward selects
//   mfrse_c, mfrte_c           E-stage forward selects
//   md_busy                    mult/div counter nonzero
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [4:0] d_a3,
   input  logic [1:0] d_tnew,
   input  logic       d_md_start,
   input  logic       d_md_op,
   input  logic       d_is_md,
   output logic       stall,
   output logic [1:0] mfrsd_c,
   output logic [1:0] mfrtd_c,
   output logic [1:0] mfrse_c,
   output logic [1:0] mfrte_c,
   output logic       md_busy
);

   localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CNT_W  = $clog2(MD_MAX + 1);

   slot_t d_slot;
   slot_t e_slot;
   slot_t m_slot;
   slot_t w_slot;

   logic             reg_stall;
   logic             md_stall;
   logic [CNT_W-1:0] md_cnt_d;
   logic [CNT_W-1:0] md_cnt_q;

   assign d_slot = '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew,
                     md_start: d_md_start, md_op: d_md_op};

   hz_slot u_slot_e (
      .clk    (clk),
      .reset  (reset),
      .bubble (stall),
      .din    (d_slot),
      .dout   (e_slot)
   );

   hz_slot #(.DEC_TNEW(1'b1)) u_slot_m (
      .clk    (clk),
      .reset  (reset),
      .bubble (1'b0),
      .din    (e_slot),
      .dout   (m_slot)
   );

   hz_slot #(.CLR_TNEW(1'b1)) u_slot_w (
      .clk    (clk),
      .reset  (reset),
      .bubble (1'b0),
      .din    (m_slot),
      .dout   (w_slot)
   );

   // E is always a bubble while an MD stall holds D, so a load never
   // collides with a countdown in progress.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (e_slot.md_start) begin
         md_cnt_d = e_slot.md_op ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) md_cnt_q <= '0;
      else        md_cnt_q <= md_cnt_d;
   end

   assign md_busy   = (md_cnt_q != '0);
   assign reg_stall = reg_hazard(d_rs, d_tuse_rs, e_slot, m_slot)
                    | reg_hazard(d_rt, d_tuse_rt, e_slot, m_slot);
   assign md_stall  = d_is_md & (e_slot.md_start | md_busy);
   assign stall     = reg_stall | md_stall;

   assign mfrsd_c = fwd_sel(d_rs,      m_slot, w_slot, RF_RD1);
   assign mfrtd_c = fwd_sel(d_rt,      m_slot, w_slot, RF_RD2);
   assign mfrse_c = fwd_sel(e_slot.rs, m_slot, w_slot, RF_RD1);
   assign mfrte_c = fwd_sel(e_slot.rt, m_slot, w_slot, RF_RD2);

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [4:0] d_rs, d_rt, d_a3;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       d_md_start, d_md_op, d_is_md;
   logic       stall, md_busy;
   logic [1:0] mfrsd_c, mfrtd_c, mfrse_c, mfrte_c;

   hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_a3       (d_a3),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_op    (d_md_op),
      .d_is_md    (d_is_md),
      .stall      (stall),
      .mfrsd_c    (mfrsd_c),
      .mfrtd_c    (mfrtd_c),
      .mfrse_c    (mfrse_c),
      .mfrte_c    (mfrte_c),
      .md_busy    (md_busy)
   );

   // Reference model: hist[k] is the instruction that entered E k cycles
   // ago; its remaining latency is max(tnew - k, 0). The MD unit is a
   // busy-until absolute cycle number.
   typedef struct {
      int rs; int rt; int a3; int tnew; bit md_start; bit md_op;
   } instr_t;

   instr_t hist [3];
   instr_t bub;
   int     cyc = 0;
   int     md_end = 0;
   bit     model_ok = 1'b0;
   int     n_tests = 0;
   int     n_fail = 0;

   int last_stall, last_busy, last_rsd, last_rtd, last_rse, last_rte;

   task automatic chk_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int left(input instr_t i, input int age);
      return (i.tnew > age) ? i.tnew - age : 0;
   endfunction

   function automatic int exp_fwd(input int src);
      if (src == 0) return 0;
      if (hist[1].a3 == src && left(hist[1], 1) == 0) return 1;
      if (hist[2].a3 == src) return 2;
      return 0;
   endfunction

   function automatic bit exp_hz(input int src, input int tuse);
      if (src == 0 || tuse == 3) return 1'b0;
      return (hist[0].a3 == src && left(hist[0], 0) > tuse) ||
             (hist[1].a3 == src && left(hist[1], 1) > tuse);
   endfunction

   task automatic step(input bit rst, input int rs, input int rt,
                       input int tu_rs, input int tu_rt, input int a3,
                       input int tnew, input bit ms, input bit mo, input bit ismd);
      instr_t ni;
      bit     e_stall, busy;
      reset = rst;
      d_rs = 5'(rs);  d_rt = 5'(rt);  d_a3 = 5'(a3);
      d_tuse_rs = 2'(tu_rs);  d_tuse_rt = 2'(tu_rt);  d_tnew = 2'(tnew);
      d_md_start = ms;  d_md_op = mo;  d_is_md = ismd;
      #2;
      busy    = (cyc < md_end);
      e_stall = exp_hz(rs, tu_rs) | exp_hz(rt, tu_rt) |
                (ismd && (hist[0].md_start || busy));
      if (model_ok) begin
         chk_eq("stall",   int'(stall),   int'(e_stall));
         chk_eq("md_busy", int'(md_busy), int'(busy));
         chk_eq("mfrsd_c", int'(mfrsd_c), exp_fwd(rs));
         chk_eq("mfrtd_c", int'(mfrtd_c), exp_fwd(rt));
         chk_eq("mfrse_c", int'(mfrse_c), exp_fwd(hist[0].rs));
         chk_eq("mfrte_c", int'(mfrte_c), exp_fwd(hist[0].rt));
      end
      last_stall = int'(stall);   last_busy = int'(md_busy);
      last_rsd = int'(mfrsd_c);   last_rtd = int'(mfrtd_c);
      last_rse = int'(mfrse_c);   last_rte = int'(mfrte_c);
      ni = '{rs, rt, a3, tnew, ms, mo};
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 3; k++) hist[k] = bub;
         md_end   = 0;
         model_ok = 1'b1;
      end else begin
         if (hist[0].md_start)
            md_end = cyc + 1 + (hist[0].md_op ? DIV_CYC : MULT_CYC);
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = e_stall ? bub : ni;
      end
      cyc++;
      #1;
   endtask

   task automatic nop();
      step(1'b1, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic md_release(input bit op, input int exp_cycles, input string tag);
      int n;
      do_reset();
      step(1'b1, 0, 0, 3, 3, 0, 0, 1'b1, op, 1'b1);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b1);
         if (last_stall == 0) break;
         n++;
      end
      chk_eq(tag, n, exp_cycles);
   endtask

   initial begin
      bub = '{0, 0, 0, 0, 1'b0, 1'b0};
      for (int k = 0; k < 3; k++) hist[k] = bub;

      // Reset with arbitrary D inputs
      step(1'b0, 5, 6, 0, 1, 7, 2, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1, 2, 1, 0, 3, 1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4, 5, 0, 0, 6, 2, 1'b0, 1'b1, 1'b1);
      chk_eq("rst_stall", last_stall, 0);
      chk_eq("rst_busy",  last_busy,  0);
      chk_eq("rst_sel",   last_rsd + last_rtd + last_rse + last_rte, 0);
      do_reset();

      // ALU -> ALU
      step(1'b1, 0, 0, 3, 3, 1, 1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      chk_eq("alu_alu_stall", last_stall, 0);
      nop();
      chk_eq("alu_alu_fwd", last_rse, 1);
      nop(); nop();

      // Load-use
      step(1'b1, 0, 0, 3, 3, 2, 2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      chk_eq("lu_stall1", last_stall, 1);
      step(1'b1, 2, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      chk_eq("lu_stall2", last_stall, 0);
      nop();
      chk_eq("lu_fwd", last_rse, 2);
      nop(); nop();

      // Branch after ALU
      step(1'b1, 0, 0, 3, 3, 3, 1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      chk_eq("br_stall1", last_stall, 1);
      step(1'b1, 3, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      chk_eq("br_stall2", last_stall, 0);
      chk_eq("br_fwd", last_rsd, 1);
      nop(); nop();

      // $0 producer/consumer
      step(1'b1, 0, 0, 3, 3, 0, 1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk_eq("r0_stall", last_stall, 0);
      chk_eq("r0_fwd", last_rsd, 0);

      // Mult/div then mflo
      md_release(1'b0, 6, "mult_stall_cycles");
      md_release(1'b1, 11, "div_stall_cycles");

      // Reset mid-multiply aborts the countdown
      do_reset();
      step(1'b1, 0, 0, 3, 3, 0, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b1);
      chk_eq("abort_busy",  last_busy,  0);
      chk_eq("abort_stall", last_stall, 0);

      // Randomized traffic on a small register window to force hazards
      for (int i = 0; i < 3000; i++) begin
         bit ismd, ms;
         ismd = ($urandom_range(0, 7) == 0);
         ms   = ismd && ($urandom_range(0, 1) == 1);
         step(($urandom_range(0, 99) != 0),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2),
              ms, 1'($urandom_range(0, 1)), ismd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
